// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared opcode, ALU-op, register-select and state encodings for the 8-bit micro
package up_pkg;

  // Instruction opcodes (first nibble)
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_SPI  = 4'hB;
  localparam logic [3:0] OP_SPD  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operations driven on a_op; opcodes 0x0-0x6 map straight onto these
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_B   = 4'd7;

  // Register write selects: bit2 clear takes data_in, bit2 set takes the ALU result
  localparam logic [2:0] SEL_I0 = 3'b000;
  localparam logic [2:0] SEL_I1 = 3'b001;
  localparam logic [2:0] SEL_I2 = 3'b010;
  localparam logic [2:0] SEL_I3 = 3'b011;
  localparam logic [2:0] SEL_O0 = 3'b100;
  localparam logic [2:0] SEL_O1 = 3'b101;
  localparam logic [2:0] SEL_O2 = 3'b110;
  localparam logic [2:0] SEL_O3 = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_INC    = 3'd1,
    S_FETCH2 = 3'd2,
    S_INC2   = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_TEST   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Write select for register r taking the ALU result
  function automatic logic [2:0] sel_alu(input logic [1:0] r);
    return {1'b1, r};
  endfunction

  // Write select for register r taking memory data
  function automatic logic [2:0] sel_mem(input logic [1:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/up_decode.sv
// rtl/up_decode.sv - combinational opcode classifier
module up_decode
  import up_pkg::*;
(
  input  logic [3:0] op,
  output logic       two_nibble,
  output logic       is_alu,
  output logic       is_ld,
  output logic       is_jmp,
  output logic       is_jz,
  output logic       is_halt
);

  // Opcodes up to JZ carry an operand nibble; ALU group is ADD..XOR (MOV handled apart)
  always_comb begin
    two_nibble = (op <= OP_JZ);
    is_alu     = (op >= OP_ADD) && (op <= OP_XOR);
    is_ld      = (op == OP_LD);
    is_jmp     = (op == OP_JMP);
    is_jz      = (op == OP_JZ);
    is_halt    = (op == OP_HALT);
  end

endmodule

// File: rtl/up_control.sv
// rtl/up_control.sv - hard-wired control FSM sequencing fetch, decode and execute
module up_control
  import up_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir,
  input  logic [7:0] dp_data_out,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       a_sel_in_a,
  output logic       a_sel_in_b,
  output logic [3:0] a_op,
  output logic       ir_we,
  output logic       pc_we,
  output logic       sp_we,
  output logic       rb_we,
  output logic [1:0] rb_sel_out_a,
  output logic [1:0] rb_sel_out_b,
  output logic [2:0] rb_sel_in,
  output logic       halted
);

  state_t     state;
  state_t     next_state;
  logic [3:0] op_q;
  logic [1:0] ra;
  logic [1:0] rb;

  logic [3:0] dec_op;
  logic       two_nibble;
  logic       is_alu;
  logic       is_ld;
  logic       is_jmp;
  logic       is_jz;
  logic       is_halt;

  // In INC the opcode is still on ir (op_q loads at the end of that cycle)
  assign dec_op = (state == S_INC) ? ir : op_q;

  up_decode u_decode (
    .op         (dec_op),
    .two_nibble (two_nibble),
    .is_alu     (is_alu),
    .is_ld      (is_ld),
    .is_jmp     (is_jmp),
    .is_jz      (is_jz),
    .is_halt    (is_halt)
  );

  // State register plus opcode/operand latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= 4'd0;
      ra    <= 2'd0;
      rb    <= 2'd0;
    end else begin
      state <= next_state;
      if (state == S_INC) begin
        op_q <= ir;
      end
      if (state == S_INC2) begin
        ra <= ir[3:2];
        rb <= ir[1:0];
      end
    end
  end

  // Next-state and control strobes; everything held at 0 while rst is high
  always_comb begin
    next_state   = state;
    mem_rd       = 1'b0;
    a_sel_in_a   = 1'b0;
    a_sel_in_b   = 1'b0;
    a_op         = ALU_ADD;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    sp_we        = 1'b0;
    rb_we        = 1'b0;
    rb_sel_out_a = 2'd0;
    rb_sel_out_b = 2'd0;
    rb_sel_in    = SEL_I0;
    halted       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH, S_FETCH2: begin
          // PC passes through the ALU onto the address bus
          a_op   = ALU_B;
          mem_rd = 1'b1;
          ir_we  = mem_ack;
          if (mem_ack) begin
            next_state = (state == S_FETCH) ? S_INC : S_INC2;
          end
        end
        S_INC, S_INC2: begin
          // pc <= pc + r0, r0 being the architectural constant 1
          a_op         = ALU_ADD;
          a_sel_in_a   = 1'b1;
          rb_sel_out_a = 2'd0;
          pc_we        = 1'b1;
          if (state == S_INC) begin
            if (is_halt)         next_state = S_HALT;
            else if (two_nibble) next_state = S_FETCH2;
            else                 next_state = S_EXEC;
          end else begin
            if (is_ld)      next_state = S_MEM;
            else if (is_jz) next_state = S_TEST;
            else            next_state = S_EXEC;
          end
        end
        S_EXEC: begin
          next_state = S_FETCH;
          if (is_alu) begin
            a_op         = op_q;
            a_sel_in_a   = 1'b1;
            a_sel_in_b   = 1'b1;
            rb_sel_out_a = ra;
            rb_sel_out_b = rb;
            rb_sel_in    = sel_alu(ra);
            rb_we        = (ra != 2'd0);
          end else if (op_q == OP_MOV) begin
            a_op         = ALU_B;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = rb;
            rb_sel_in    = sel_alu(ra);
            rb_we        = (ra != 2'd0);
          end else if (is_jmp || is_jz) begin
            a_op         = ALU_B;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = rb;
            pc_we        = 1'b1;
          end else if (op_q == OP_SPI || op_q == OP_SPD) begin
            a_op         = (op_q == OP_SPI) ? ALU_ADD : ALU_SUB;
            a_sel_in_a   = 1'b0;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = 2'd0;
            sp_we        = 1'b1;
          end
        end
        S_MEM: begin
          // Address is register rb; data_in lands in ra on ack
          a_op         = ALU_B;
          a_sel_in_b   = 1'b1;
          rb_sel_out_b = rb;
          mem_rd       = 1'b1;
          rb_sel_in    = sel_mem(ra);
          if (mem_ack) begin
            rb_we      = (ra != 2'd0);
            next_state = S_FETCH;
          end
        end
        S_TEST: begin
          a_op         = ALU_B;
          a_sel_in_b   = 1'b1;
          rb_sel_out_b = ra;
          next_state   = (dp_data_out == 8'd0) ? S_EXEC : S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/up_control.md
# up_control

Microcoded-free, hard-wired control FSM for the 8-bit micro: the consumer of the datapath's `ir` nibble and the driver of every datapath control strobe (ALU operand selects, ALU op, IR/PC/SP/register-block write enables). It fetches 4-bit instruction nibbles over a single-request memory read handshake, sequences one- and two-nibble instructions, and uses register r0 as the architectural constant 1 for PC/SP stepping.

## Interface
Parameters:
- none; opcode, ALU-op, select and state encodings come from `up_pkg`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ir` in 4: current instruction nibble from the datapath.
- `dp_data_out` in 8: datapath ALU result; used only for the JZ zero test.
- `mem_ack` in 1: memory read complete; `data_in` is valid at the datapath this cycle.
- `mem_rd` out 1: memory read request; the address is `dp_data_out`.
- `a_sel_in_a` out 1: 1 = register-block port A, 0 = SP.
- `a_sel_in_b` out 1: 1 = register-block port B, 0 = PC.
- `a_op` out 4: ALU op (ADD=0 … XOR=6, B=7).
- `ir_we`, `pc_we`, `sp_we`, `rb_we` out 1 each: datapath write enables.
- `rb_sel_out_a`, `rb_sel_out_b` out 2 each: register read selects.
- `rb_sel_in` out 3: register write select; bit2 = 1 takes ALU result, bit2 = 0 takes `data_in`.
- `halted` out 1: high in HALT.

## Operation
- ISA: the opcode nibble is optionally followed by an operand nibble {ra[3:2], rb[1:0]}.
  - 0x0–0x6: ALU, ra <= ra op rb.
  - 0x7: MOV, ra <= rb (op B).
  - 0x8: LD, ra <= mem[rb].
  - 0x9: JMP, pc <= rb.
  - 0xA: JZ, if ra==0 then pc <= rb.
  - 0xB: SPI, sp <= sp+r0.
  - 0xC: SPD, sp <= sp−r0.
  - 0xD, 0xE: NOP.
  - 0xF: HALT.
- 0x0–0xA are two-nibble; 0xB–0xF are one-nibble.
- States: FETCH, INC, FETCH2, INC2, EXEC, MEM, TEST, HALT.
- FETCH/FETCH2:
  - Drives a_op=B, a_sel_in_b=0, so the address is the PC.
  - mem_rd=1; the state is held until mem_ack.
  - ir_we=1 only in the ack cycle.
- INC/INC2:
  - PC step: ADD, a_sel_in_a=1, rb_sel_out_a=0, a_sel_in_b=0, pc_we=1 (pc <= pc+1).
  - INC latches `ir` into op_q, then goes to FETCH2 (two-nibble), EXEC (one-nibble) or HALT (0xF).
  - INC2 latches ra/rb from `ir`, then goes to MEM (LD), TEST (JZ) or EXEC.
- EXEC: performs the op per the ISA, then goes to FETCH.
- MEM:
  - Drives a_op=B, a_sel_in_b=1, rb_sel_out_b=rb, mem_rd=1.
  - On ack: rb_we with rb_sel_in={0,ra}, then FETCH.
- TEST: drives a_op=B, rb_sel_out_b=ra, then goes to EXEC if dp_data_out==0, else FETCH.
- r0 is read-only: any write targeting r0 is suppressed (rb_we=0); the instruction otherwise completes.
- mem_ack while mem_rd=0 is ignored.
- Undriven strobes are 0 in every state; selects default to 0.
- HALT is terminal until rst.

## Timing
- All outputs are combinational from state plus latched operands.
- While rst=1, every output is forced to 0.
- State resets to FETCH, op_q/ra/rb to 0.
- First mem_rd is asserted in the first cycle after rst falls.
- With zero-wait memory (ack in the same cycle as mem_rd), cycles per instruction:
  - one-nibble: 3;
  - ALU/MOV/JMP: 5;
  - LD: 5;
  - JZ: 6 taken, 5 not taken.
- Each memory wait cycle adds 1.
- mem_rd stays high and all write enables stay low while waiting.
- rst asserted mid-instruction aborts it at the next edge; no partial write occurs after that edge.

## Structure
- `up_pkg` holds:
  - opcode constants, ALU op constants (shared with the datapath);
  - rb_sel_in SEL_I*/SEL_O* codes;
  - the state enum encoding.
- Sub-module `up_decode`: combinational op_q → {two_nibble, is_alu, is_ld, is_jmp, is_jz, is_halt}.

## Test plan
- Reset, then release with zero-wait memory → cycle 1: mem_rd=1, a_op=7, a_sel_in_b=0; cycle 2: pc_we=1, a_op=0, a_sel_in_a=1, rb_sel_out_a=0.
- Nibbles 0x1, 0x9 (SUB r2,r1), ack delayed 2 cycles each → mem_rd held 3 cycles per fetch; EXEC has a_op=1, rb_sel_out_a=2, rb_sel_out_b=1, rb_sel_in=6, rb_we=1.
- Nibbles 0x0, 0x1 (ADD r0,r1) → EXEC with rb_we=0, then back to FETCH.
- LD r3,[r2] (0x8, 0xE) → MEM: mem_rd=1, rb_sel_out_b=2; on ack rb_we=1, rb_sel_in=3.
- JZ r1,r2 with dp_data_out=0x00 → EXEC pc_we=1, a_sel_in_b=1, rb_sel_out_b=2; with dp_data_out=0x05 → no pc_we, direct to FETCH.
- 0xC then 0xF → sp_we=1 with a_op=1, a_sel_in_a=0; then halted=1, mem_rd=0 indefinitely; rst mid-FETCH wait → all outputs 0 next cycle.
